fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Round-robin scheduler that shares one `fpu` instance among `NUM_REQ` requesters, such as the integer pipeline and the vector/coprocessor path. It accepts one operation at a time over a valid/ready handshake and drives the FPU operand/operation inputs from latched registers. It waits a fixed latency, captures the result, and returns it to the originating requester with status flags. It sits between the CPU issue logic and the `fpu` datapath.

## Interface
- `NUM_REQ`, 2: number of requesters, range 2–8.
- `FPU_LATENCY`, 1: FPU clock edges from operands sampled to result valid, range ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operation request.
- `req_ready`  out  NUM_REQ  one-hot accept; an op transfers when `req_valid[i] & req_ready[i]`.
- `req_a`  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NUM_REQ  operand B, packed the same way.
- `req_op`  in  3*NUM_REQ  operation; 0 add, 1 sub, 2 mul, 3 div, 4–7 illegal.
- `rsp_valid`  out  NUM_REQ  one-hot response valid, held until accepted.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_result`  out  32  result of the completed op.
- `rsp_divz`  out  1  set when op is div and operand B is 0; result is 0.
- `rsp_err`  out  1  set when op is 4–7; result is 0.
- `fpu_a`, `fpu_b`  out  32  to FPU `operand_a`/`operand_b`.
- `fpu_op`  out  3  to FPU `operation`.
- `fpu_result`  in  32  from FPU `result`. FPU `valid` is not used.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  16  count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE:**
  - Arbitration is round-robin. Search starts at `last_grant+1` modulo NUM_REQ; the first requester with `req_valid` high wins.
  - `req_ready` is combinational: one-hot on the winner, only in IDLE, and all zero if no request is present.
  - On transfer: latch a, b, op, and the requester id; set `last_grant` to the id; clear `cnt`; go to EXEC.
- **EXEC:**
  - `fpu_a`, `fpu_b`, `fpu_op` are driven from the latched registers for the whole state.
  - `cnt` increments each cycle.
  - When `cnt == FPU_LATENCY`: capture `fpu_result` into `rsp_result`, compute `rsp_divz`/`rsp_err` from the latched op and b, and go to RESP.
- **RESP:**
  - `rsp_valid[id]` is high; `rsp_result` and the flags are stable.
  - On `rsp_ready[id]`: increment `ops_done` and go to IDLE.
  - `rsp_ready` on non-granted bits is ignored.
- **Outside EXEC:** `fpu_a`, `fpu_b`, `fpu_op` hold their last latched value. Reset value is 0.
- **Flags:**
  - `rsp_divz = (op==3) && (b==0)`.
  - `rsp_err = (op>=4)`.
  - Flags are informational: the captured `fpu_result` (0 in both cases) is returned unchanged.
- **No starvation:** a continuously valid requester is granted within NUM_REQ operations.

## Timing
- **Reset values:**
  - `req_ready`, `rsp_valid`: 0.
  - `rsp_result`, `rsp_divz`, `rsp_err`: 0.
  - `fpu_a`, `fpu_b`, `fpu_op`: 0.
  - `busy`, `ops_done`: 0.
  - State: IDLE.
  - `last_grant`: NUM_REQ-1, so requester 0 wins first.
- **Latency:** transfer in cycle T means EXEC occupies T+1 … T+1+FPU_LATENCY, and `rsp_valid` rises in cycle T+FPU_LATENCY+2 (T+3 at default).
- **Throughput:** the response handshake cycle is followed by one IDLE cycle before the next transfer. Minimum issue interval is FPU_LATENCY+3 cycles when `rsp_ready` is held high.
- **Requests while busy:** `req_ready` stays 0 and requesters must hold `req_valid` and their operands. Operand changes after transfer have no effect.
- **Reset mid-operation:** `rst` in EXEC or RESP returns to IDLE on the next edge. The in-flight op is discarded with no response, and `ops_done` is cleared.
- **Simultaneous requests:** exactly one `req_ready` bit is set per IDLE cycle.

## Test plan
- **Single op:** after reset, req0 issues op 0 with a=5, b=7 in cycle T. Required: `req_ready=01` in T; `rsp_valid=01` with `rsp_result=12` in T+3; flags 0; `ops_done=1` after handshake.
- **Round-robin:** req0 and req1 both continuously valid with mul 3×4 and sub 10−4. Required: grants alternate 0,1,0,1; responses 12 then 6; neither requester is granted twice in a row.
- **Backpressure:** req1 issues div 100/7 and `rsp_ready` is held low for 5 cycles. Required: `rsp_valid[1]` and `rsp_result=14` stable throughout, no new `req_ready`, and completion on the first `rsp_ready[1]`.
- **Flags:** div 9/0 gives result 0 and `rsp_divz=1`; op 5 with a=1, b=1 gives result 0 and `rsp_err=1`.
- **Reset mid-op:** assert `rst` in the first EXEC cycle. Required: all outputs at reset values next cycle, no `rsp_valid`, and the next request is served normally with requester 0 winning first.
- **Counter wrap:** preload or run 65536 ops. Required: `ops_done` reads 0 after the 65536th handshake.

Source files
------------

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin scheduler sharing one fixed-latency FPU among NUM_REQ requesters
module fpu_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FPU_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [3*NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_divz,
  output logic                   rsp_err,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [2:0]             fpu_op,
  input  logic [31:0]            fpu_result,
  output logic                   busy,
  output logic [15:0]            ops_done
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FPU_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_id;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [2:0]    r_op;
  logic [31:0]   r_result;
  logic          r_divz;
  logic          r_err;
  logic [15:0]   r_ops;

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_win;
  logic          w_found;
  logic [31:0]   w_a;
  logic [31:0]   w_b;
  logic [2:0]    w_op;
  logic          w_exec_end;

  // Walk the requesters starting just after the last grant, wrapping at NUM_REQ.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_a  = req_a[32*i +: 32];
        w_b  = req_b[32*i +: 32];
        w_op = req_op[3*i +: 3];
      end
    end
  end

  assign w_exec_end = (r_cnt == CW'(FPU_LATENCY));

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_win] = 1'b1;
          w_next           = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_exec_end) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_id] = 1'b1;
        if (rsp_ready[r_id]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(NUM_REQ - 1);
      r_id     <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_divz   <= 1'b0;
      r_err    <= 1'b0;
      r_ops    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a    <= w_a;
            r_b    <= w_b;
            r_op   <= w_op;
            r_id   <= w_win;
            r_last <= w_win;
            r_cnt  <= '0;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt + 1'b1;
          // Flags come from the latched request; the FPU result passes through untouched.
          if (w_exec_end) begin
            r_result <= fpu_result;
            r_divz   <= (r_op == 3'd3) && (r_b == 32'd0);
            r_err    <= r_op[2];
          end
        end
        S_RESP: begin
          if (rsp_ready[r_id]) r_ops <= r_ops + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign fpu_a      = r_a;
  assign fpu_b      = r_b;
  assign fpu_op     = r_op;
  assign rsp_result = r_result;
  assign rsp_divz   = r_divz;
  assign rsp_err    = r_err;
  assign busy       = (r_state != S_IDLE);
  assign ops_done   = r_ops;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - scoreboard bench for fpu_arbiter with a behavioural FPU and arbitration model
module tb_fpu_arbiter;
  localparam int N = 3;
  localparam int L = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3*N-1:0]  req_op;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_result;
  logic            rsp_divz;
  logic            rsp_err;
  logic [31:0]     fpu_a;
  logic [31:0]     fpu_b;
  logic [2:0]      fpu_op;
  logic [31:0]     fpu_result;
  logic            busy;
  logic [15:0]     ops_done;

  always #5 clk = ~clk;

  fpu_arbiter #(.NUM_REQ(N), .FPU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_divz(rsp_divz), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_result(fpu_result),
    .busy(busy), .ops_done(ops_done)
  );

  function automatic logic [31:0] fpu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == 0) ? 32'd0 : a / b;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural FPU: the result of sampled operands appears L edges later.
  logic [31:0] fpu_pipe [L];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_model(fpu_op, fpu_a, fpu_b);
    for (int i = 1; i < L; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_result = fpu_pipe[L-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          due;
  } item_t;

  item_t       sb[$];
  int          glog[$];
  logic [15:0] m_ops  = 16'd0;
  int          m_last = N - 1;
  bit          m_busy = 1'b0;
  bit          p_rst  = 1'b0;
  logic [31:0] m_fa   = 32'd0;
  logic [31:0] m_fb   = 32'd0;
  logic [2:0]  m_fop  = 3'd0;

  // Monitor: reference model of grants, latency and response contents.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [N-1:0] hs;
    item_t        it;
    int           w;
    cyc++;
    if (p_rst) begin
      chk("rst_result", rsp_result, 0);
      chk("rst_divz", rsp_divz, 0);
      chk("rst_err", rsp_err, 0);
    end
    w = -1;
    for (int k = 1; k <= N; k++)
      if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
    exp_rdy = '0;
    if (!m_busy && w >= 0) exp_rdy[w] = 1'b1;
    exp_rv = '0;
    if (sb.size() > 0 && cyc >= sb[0].due) exp_rv[sb[0].id] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("busy", busy, m_busy);
    chk("ops_done", ops_done, m_ops);
    chk("fpu_a", fpu_a, m_fa);
    chk("fpu_b", fpu_b, m_fb);
    chk("fpu_op", fpu_op, m_fop);
    if (exp_rv != 0) begin
      chk("rsp_result", rsp_result, fpu_model(sb[0].op, sb[0].a, sb[0].b));
      chk("rsp_divz", rsp_divz, (sb[0].op == 3) && (sb[0].b == 0));
      chk("rsp_err", rsp_err, sb[0].op >= 4);
    end
    if (rst) begin
      sb.delete();
      m_last = N - 1; m_busy = 0; m_ops = 0;
      m_fa = 0; m_fb = 0; m_fop = 0;
      p_rst = 1'b1;
    end else begin
      p_rst = 1'b0;
      hs = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          it.id  = i;
          it.a   = req_a[32*i +: 32];
          it.b   = req_b[32*i +: 32];
          it.op  = req_op[3*i +: 3];
          it.due = cyc + L + 2;
          sb.push_back(it);
          glog.push_back(i);
          m_last = i; m_busy = 1'b1;
          m_fa = it.a; m_fb = it.b; m_fop = it.op;
        end
      end
      if (exp_rv != 0 && (rsp_ready & exp_rv) != 0) begin
        void'(sb.pop_front());
        m_busy = 1'b0;
        m_ops  = m_ops + 16'd1;
      end
    end
  end

  task automatic put(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = 1'b1;
    req_op[3*i +: 3]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic wait_acc(input int i, input string name, output logic [N-1:0] rdy);
    bit ok;
    ok  = 1'b0;
    rdy = '0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i] && !rst) begin
        ok  = 1'b1;
        rdy = req_ready;
      end
    end
    chk({name, "_accept"}, ok, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, input logic [31:0] er, input bit edz, input bit eer, input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid[i] && rsp_ready[i]) begin
        got = 1'b1;
        chk({name, "_result"}, rsp_result, er);
        chk({name, "_divz"}, rsp_divz, edz);
        chk({name, "_err"}, rsp_err, eer);
      end
    end
    chk({name, "_done"}, got, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit edz, input bit eer, input string name);
    logic [N-1:0] rdy;
    put(i, op, a, b);
    wait_acc(i, name, rdy);
    wait_rsp(i, er, edz, eer, name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rdy;
    logic [N-1:0] acc;
    logic [2:0]   rop;
    logic [31:0]  ra;
    logic [31:0]  rb;
    bit           ok;
    int           gid;
    int           g0;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;

    // Single op from requester 0.
    put(0, 3'd0, 32'd5, 32'd7);
    wait_acc(0, "single", rdy);
    chk("single_ready", rdy, 3'b001);
    wait_rsp(0, 32'd12, 1'b0, 1'b0, "single");
    @(negedge clk);
    chk("single_ops_done", ops_done, 1);
    @(posedge clk); #1;

    // Round robin between two continuously valid requesters.
    do_reset();
    g0 = glog.size();
    put(0, 3'd2, 32'd3, 32'd4);
    put(1, 3'd1, 32'd10, 32'd4);
    for (int n = 0; n < 4; n++) begin
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        @(negedge clk);
        for (int i = 0; i < N; i++)
          if (req_valid[i] && req_ready[i]) begin ok = 1'b1; gid = i; end
      end
      chk("rr_accept", ok, 1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (L + 4) @(posedge clk);
    #1;
    chk("rr_count", glog.size() - g0, 4);
    for (int n = 0; n < 4 && g0 + n < glog.size(); n++) chk("rr_grant", glog[g0+n], n % 2);

    // Backpressure: response to requester 1 held, non-granted ready bits ignored.
    rsp_ready = 3'b101;
    put(1, 3'd3, 32'd100, 32'd7);
    wait_acc(1, "bp", rdy);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) ok = 1'b1;
    end
    chk("bp_rise", ok, 1);
    @(posedge clk); #1;
    put(0, 3'd0, 32'd1, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 3'b010);
      chk("bp_result", rsp_result, 32'd14);
      chk("bp_no_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    chk("bp_complete", rsp_valid & rsp_ready, 3'b010);
    @(posedge clk); #1;
    wait_acc(0, "bp_next", rdy);
    wait_rsp(0, 32'd2, 1'b0, 1'b0, "bp_next");

    // Flags.
    run_op(2, 3'd3, 32'd9, 32'd0, 32'd0, 1'b1, 1'b0, "divz");
    run_op(0, 3'd5, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, "illegal");

    // Reset in the first EXEC cycle discards the op.
    put(2, 3'd0, 32'd1, 32'd2);
    wait_acc(2, "midrst", rdy);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_fpu_a", fpu_a, 0);
    chk("midrst_ops_done", ops_done, 0);
    @(posedge clk); #1;
    put(1, 3'd1, 32'd20, 32'd5);
    put(0, 3'd2, 32'd6, 32'd7);
    wait_acc(0, "post_rst", rdy);
    chk("post_rst_ready", rdy, 3'b001);
    wait_rsp(0, 32'd42, 1'b0, 1'b0, "post_rst0");
    wait_acc(1, "post_rst1", rdy);
    wait_rsp(1, 32'd15, 1'b0, 1'b0, "post_rst1");

    // Counter wrap from a preloaded value.
    force dut.r_ops = 16'hFFFE;
    m_ops = 16'hFFFE;
    @(posedge clk); #1;
    release dut.r_ops;
    run_op(1, 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, "wrap1");
    @(negedge clk);
    chk("wrap_ffff", ops_done, 16'hFFFF);
    @(posedge clk); #1;
    run_op(2, 3'd0, 32'd4, 32'd3, 32'd7, 1'b0, 1'b0, "wrap2");
    @(negedge clk);
    chk("wrap_zero", ops_done, 16'h0000);
    @(posedge clk); #1;

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          rop = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
          ra  = $urandom;
          rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
          put(i, rop, ra, rb);
        end
      end
      rsp_ready = N'($urandom);
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (L + 10) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
